// File: rtl/sph_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sph_sum_accumulator
// Brief    : Sums PARTICLE_COUNT kernel terms per particle. A density sum is
//            finalised into 1/rho and pressure tables; a force sum is emitted.
//            Build option ACC_SATURATE_EN: saturating (instead of wrapping) add.
// Revision : 1.0 - initial release
// ============================================================================
module sph_sum_accumulator #(
  parameter int                    PARTICLE_COUNT = 4,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    FRAC_BITS      = 8,
  parameter int                    ACC_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] REST_DENSITY   = 16'h0100,
  parameter logic [DATA_WIDTH-1:0] STIFFNESS      = 16'h0040
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              next_sum,
  input  logic                              is_density_task,
  input  logic [$clog2(PARTICLE_COUNT)-1:0] main_index,
  input  logic [$clog2(PARTICLE_COUNT)-1:0] req_index,
  input  logic                              term_valid,
  input  logic [DATA_WIDTH-1:0]             term_data,
  output logic [DATA_WIDTH-1:0]             density_reciprocal,
  output logic [DATA_WIDTH-1:0]             pressure,
  output logic                              done_accumulating,
  output logic                              force_valid,
  output logic [$clog2(PARTICLE_COUNT)-1:0] force_index,
  output logic [DATA_WIDTH-1:0]             force_sum,
  output logic                              overflow
);

  localparam int IDX_W  = $clog2(PARTICLE_COUNT);
  localparam int CNT_W  = $clog2(PARTICLE_COUNT + 1);
  localparam int STEP_W = $clog2(DATA_WIDTH);
  localparam int AW_MAX = (ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH;
  localparam int WW     = AW_MAX + 2;
  localparam int PW     = 2 * DATA_WIDTH + 3;

  localparam logic [63:0] DIVIDEND = 64'd1 << (2 * FRAC_BITS);
  localparam logic [63:0] DIV_HI64 = DIVIDEND >> DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] DIV_LO = DIVIDEND[DATA_WIDTH-1:0];

  localparam logic signed [WW-1:0] RHO_MAX_W = {{(WW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic signed [WW-1:0] F_MAX_W   = {{(WW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] F_MIN_W   = {{(WW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX_W   = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN_W   = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_FINAL = 3'd2,
    ST_WRITE = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  // Async assert, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n_sync;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          dens_q, dens_d;
  logic                          ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]         rho_q, rho_d;
  logic [DATA_WIDTH-1:0]         pres_q, pres_d;
  logic [DATA_WIDTH-1:0]         recip_q, recip_d;
  logic [DATA_WIDTH-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0]         quo_q, quo_d;
  logic [DATA_WIDTH-1:0]         dvd_q, dvd_d;
  logic [STEP_W-1:0]             step_q, step_d;
  logic                          busy_q, busy_d;
  logic                          fvalid_q, fvalid_d;
  logic [IDX_W-1:0]              fidx_q, fidx_d;
  logic [DATA_WIDTH-1:0]         fsum_q, fsum_d;
  logic                          wr_en;

  logic [IDX_W-1:0]              req_q;
  logic [DATA_WIDTH-1:0]         rd_recip_q, rd_pres_q;
  logic [DATA_WIDTH-1:0]         recip_tbl_q [PARTICLE_COUNT];
  logic [DATA_WIDTH-1:0]         pres_tbl_q  [PARTICLE_COUNT];

  logic signed [ACC_WIDTH-1:0]   w_term_ext;
  logic signed [ACC_WIDTH:0]     w_sum;
  logic                          w_add_ovf;
  logic [ACC_WIDTH-1:0]          w_acc_add;
  logic signed [WW-1:0]          w_acc_w;
  logic [DATA_WIDTH-1:0]         w_rho;
  logic [DATA_WIDTH-1:0]         w_force;
  logic signed [PW-1:0]          w_diff, w_prod, w_pshift;
  logic [DATA_WIDTH-1:0]         w_pres;
  logic [DATA_WIDTH:0]           w_shift;
  logic                          w_ge;
  logic                          w_div_sat;

  always_comb begin
    w_term_ext = ACC_WIDTH'($signed(term_data));
    w_sum      = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(w_term_ext);
    w_add_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
`ifdef ACC_SATURATE_EN
    if (w_add_ovf) w_acc_add = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else           w_acc_add = w_sum[ACC_WIDTH-1:0];
`else
    w_acc_add  = w_sum[ACC_WIDTH-1:0];
`endif

    w_acc_w = WW'(acc_q);
    if (w_acc_w < 0)              w_rho = '0;
    else if (w_acc_w > RHO_MAX_W) w_rho = '1;
    else                          w_rho = w_acc_w[DATA_WIDTH-1:0];

    if (w_acc_w > F_MAX_W)        w_force = OUT_MAX;
    else if (w_acc_w < F_MIN_W)   w_force = OUT_MIN;
    else                          w_force = w_acc_w[DATA_WIDTH-1:0];

    // rho and rest density are unsigned; widen before subtracting.
    w_diff   = $signed({{(PW-DATA_WIDTH){1'b0}}, w_rho})
             - $signed({{(PW-DATA_WIDTH){1'b0}}, REST_DENSITY});
    w_prod   = w_diff * $signed({{(PW-DATA_WIDTH){1'b0}}, STIFFNESS});
    w_pshift = w_prod >>> FRAC_BITS;
    if (w_pshift > P_MAX_W)       w_pres = OUT_MAX;
    else if (w_pshift < P_MIN_W)  w_pres = OUT_MIN;
    else                          w_pres = w_pshift[DATA_WIDTH-1:0];

    // Dividend bits above DATA_WIDTH are preloaded into the remainder;
    // if they already reach rho the quotient cannot fit.
    w_shift   = {rem_q, dvd_q[DATA_WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, rho_q});
    w_div_sat = (DIV_HI64 >= {{(64-DATA_WIDTH){1'b0}}, rho_q});
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dens_d   = dens_q;
    ovf_d    = ovf_q;
    rho_d    = rho_q;
    pres_d   = pres_q;
    recip_d  = recip_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvd_d    = dvd_q;
    step_d   = step_q;
    busy_d   = busy_q;
    fvalid_d = 1'b0;
    fidx_d   = fidx_q;
    fsum_d   = fsum_q;
    wr_en    = 1'b0;

    if (next_sum) begin
      state_d = ST_ACCUM;
      idx_d   = main_index;
      dens_d  = is_density_task;
      busy_d  = 1'b0;
      if (term_valid) begin
        acc_d = w_term_ext;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (cnt_q == CNT_W'(PARTICLE_COUNT)) begin
            if (dens_q) begin
              state_d = ST_FINAL;
            end else begin
              state_d  = ST_EMIT;
              fvalid_d = 1'b1;
              fidx_d   = idx_q;
              fsum_d   = w_force;
            end
          end else if (term_valid) begin
            acc_d = w_acc_add;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_add_ovf) ovf_d = 1'b1;
          end
        end
        ST_FINAL: begin
          if (!busy_q) begin
            rho_d  = w_rho;
            pres_d = w_pres;
            rem_d  = DIV_HI64[DATA_WIDTH-1:0];
            dvd_d  = DIV_LO;
            quo_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
          end else begin
            rem_d  = w_ge ? DATA_WIDTH'(w_shift - {1'b0, rho_q}) : w_shift[DATA_WIDTH-1:0];
            quo_d  = {quo_q[DATA_WIDTH-2:0], w_ge};
            dvd_d  = dvd_q << 1;
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(DATA_WIDTH - 1)) begin
              state_d = ST_WRITE;
              busy_d  = 1'b0;
              recip_d = w_div_sat ? '1 : {quo_q[DATA_WIDTH-2:0], w_ge};
            end
          end
        end
        ST_WRITE: begin
          wr_en   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EMIT:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      dens_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rho_q      <= '0;
      pres_q     <= '0;
      recip_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvd_q      <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      fvalid_q   <= 1'b0;
      fidx_q     <= '0;
      fsum_q     <= '0;
      req_q      <= '0;
      rd_recip_q <= '0;
      rd_pres_q  <= '0;
      for (int k = 0; k < PARTICLE_COUNT; k++) begin
        recip_tbl_q[k] <= '0;
        pres_tbl_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dens_q     <= dens_d;
      ovf_q      <= ovf_d;
      rho_q      <= rho_d;
      pres_q     <= pres_d;
      recip_q    <= recip_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvd_q      <= dvd_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      fvalid_q   <= fvalid_d;
      fidx_q     <= fidx_d;
      fsum_q     <= fsum_d;
      // Reads use the pre-write table contents when addresses collide.
      req_q      <= req_index;
      rd_recip_q <= recip_tbl_q[req_q];
      rd_pres_q  <= pres_tbl_q[req_q];
      if (wr_en) begin
        recip_tbl_q[idx_q] <= recip_q;
        pres_tbl_q[idx_q]  <= pres_q;
      end
    end
  end

  assign density_reciprocal = rd_recip_q;
  assign pressure           = rd_pres_q;
  assign done_accumulating  = (state_q == ST_IDLE);
  assign force_valid        = fvalid_q;
  assign force_index        = fidx_q;
  assign force_sum          = fsum_q;
  assign overflow           = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sph_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sph_sum_accumulator
// Brief    : Directed bench for sph_sum_accumulator (default and 16-bit acc).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sph_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        next_sum, is_density, term_valid;
  logic [1:0]  main_index, req_index;
  logic [15:0] term_data;

  logic [15:0] dr, pr, fs, dr16, pr16, fs16;
  logic        done, fv, ov, done16, fv16, ov16;
  logic [1:0]  fi, fi16;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, pulses;
  logic [15:0] cap_fs, cap_fs16;
  logic [1:0]  cap_fi;
  logic [15:0] rd_r, rd_p;

  always #5 clk = ~clk;

  sph_sum_accumulator dut (
    .clk_in(clk), .rst_n_in(rst_n), .next_sum(next_sum), .is_density_task(is_density),
    .main_index(main_index), .req_index(req_index), .term_valid(term_valid),
    .term_data(term_data), .density_reciprocal(dr), .pressure(pr),
    .done_accumulating(done), .force_valid(fv), .force_index(fi), .force_sum(fs),
    .overflow(ov)
  );

  sph_sum_accumulator #(.ACC_WIDTH(16)) dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .next_sum(next_sum), .is_density_task(is_density),
    .main_index(main_index), .req_index(req_index), .term_valid(term_valid),
    .term_data(term_data), .density_reciprocal(dr16), .pressure(pr16),
    .done_accumulating(done16), .force_valid(fv16), .force_index(fi16), .force_sum(fs16),
    .overflow(ov16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_sum(input logic dens, input logic [1:0] idx,
                           input logic with_term, input logic [15:0] d);
    next_sum   = 1'b1;
    is_density = dens;
    main_index = idx;
    term_valid = with_term;
    term_data  = d;
    @(negedge clk);
    next_sum   = 1'b0;
    term_valid = 1'b0;
    term_data  = '0;
  endtask

  task automatic send_term(input logic [15:0] d);
    term_valid = 1'b1;
    term_data  = d;
    @(negedge clk);
    term_valid = 1'b0;
    term_data  = '0;
  endtask

  // Counts cycles until done, capturing any force pulse on the way.
  task automatic wait_done(output int l, output int p, output logic [15:0] s,
                           output logic [1:0] i, output logic [15:0] s16);
    l = -1; p = 0; s = '0; i = '0; s16 = '0;
    for (int k = 0; k < 40; k++) begin
      if (fv) begin
        p++;
        s   = fs;
        i   = fi;
        s16 = fs16;
      end
      if (done) begin
        l = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic read_tbl(input logic [1:0] idx, output logic [15:0] r, output logic [15:0] p);
    req_index = idx;
    repeat (2) @(negedge clk);
    r = dr;
    p = pr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; next_sum = 1'b0; is_density = 1'b0; main_index = '0;
    req_index = '0; term_valid = 1'b0; term_data = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done",  32'(done), 1);
    chk("rst_fv",    32'(fv),   0);
    chk("rst_fsum",  32'(fs),   0);
    chk("rst_fidx",  32'(fi),   0);
    chk("rst_ovf",   32'(ov),   0);
    chk("rst_recip", 32'(dr),   0);
    chk("rst_pres",  32'(pr),   0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Density pass: four 1.0 terms give rho = 4.0
    start_sum(1'b1, 2'd2, 1'b0, 16'h0);
    chk("dens_done_drop", 32'(done), 0);
    repeat (4) send_term(16'h0100);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("dens_latency", 32'(lat), 19);
    chk("dens_no_pulse", 32'(pulses), 0);
    req_index = 2'd2;
    @(negedge clk);
    chk("rd_latency_old", 32'(dr), 0);
    @(negedge clk);
    chk("dens_recip", 32'(dr), 'h0040);
    chk("dens_pres",  32'(pr), 'h00C0);

    // Reset in the middle of a sum clears tables and state
    start_sum(1'b0, 2'd3, 1'b0, 16'h0);
    send_term(16'h0010);
    send_term(16'h0010);
    chk("accum_busy", 32'(done), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_done", 32'(done), 1);
    chk("mid_rst_fv",   32'(fv),   0);
    chk("mid_rst_ovf",  32'(ov),   0);
    read_tbl(2'd2, rd_r, rd_p);
    chk("mid_rst_recip", 32'(rd_r), 0);
    chk("mid_rst_pres",  32'(rd_p), 0);

    // Force pass with mixed-sign terms
    start_sum(1'b0, 2'd1, 1'b0, 16'h0);
    send_term(16'h0010);
    send_term(16'hFFF0);
    send_term(16'h0020);
    send_term(16'h0005);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("force_latency", 32'(lat),    2);
    chk("force_pulses",  32'(pulses), 1);
    chk("force_index",   32'(cap_fi), 1);
    chk("force_sum",     32'(cap_fs), 'h0025);
    chk("force_ovf",     32'(ov),     0);

    // Density sum aborted after two terms, restarted with 0.5 terms
    start_sum(1'b1, 2'd3, 1'b0, 16'h0);
    send_term(16'h0100);
    send_term(16'h0100);
    start_sum(1'b1, 2'd3, 1'b0, 16'h0);
    chk("abort_done_low", 32'(done), 0);
    repeat (4) send_term(16'h0080);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("abort_dens_latency", 32'(lat), 19);
    chk("abort_dens_pulses",  32'(pulses), 0);
    read_tbl(2'd3, rd_r, rd_p);
    chk("abort_dens_recip", 32'(rd_r), 'h0080);
    chk("abort_dens_pres",  32'(rd_p), 'h0040);

    // Force abort; restart carries its first term with next_sum; a 5th term is ignored
    start_sum(1'b0, 2'd0, 1'b0, 16'h0);
    send_term(16'h0100);
    send_term(16'h0100);
    start_sum(1'b0, 2'd0, 1'b1, 16'h0001);
    send_term(16'h0002);
    send_term(16'h0003);
    send_term(16'h0004);
    send_term(16'h0100);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("abort_force_pulses", 32'(pulses), 1);
    chk("abort_force_sum",    32'(cap_fs), 'h000A);
    chk("abort_force_index",  32'(cap_fi), 0);

    // Zero density: saturated reciprocal, negative pressure
    start_sum(1'b1, 2'd0, 1'b0, 16'h0);
    repeat (4) send_term(16'h0000);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("zero_latency", 32'(lat), 19);
    read_tbl(2'd0, rd_r, rd_p);
    chk("zero_recip", 32'(rd_r), 'hFFFF);
    chk("zero_pres",  32'(rd_p), 'hFFC0);
    read_tbl(2'd2, rd_r, rd_p);
    chk("other_entry_recip", 32'(rd_r), 0);

    // Large terms: 32-bit acc clamps force_sum; 16-bit acc overflows
    chk("pre_ovf16", 32'(ov16), 0);
    start_sum(1'b0, 2'd2, 1'b0, 16'h0);
    repeat (4) send_term(16'h7FFF);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("big_force_clamp", 32'(cap_fs), 'h7FFF);
    chk("big_ovf32",       32'(ov),     0);
    chk("big_ovf16",       32'(ov16),   1);
`ifdef ACC_SATURATE_EN
    chk("big_acc16", 32'(cap_fs16), 'h7FFF);
`else
    chk("big_acc16", 32'(cap_fs16), 'hFFFC);
`endif

    // Overflow flag is sticky across later clean sums
    start_sum(1'b0, 2'd1, 1'b0, 16'h0);
    repeat (4) send_term(16'h0001);
    wait_done(lat, pulses, cap_fs, cap_fi, cap_fs16);
    chk("small_force_sum", 32'(cap_fs),   'h0004);
    chk("small_force16",   32'(cap_fs16), 'h0004);
    chk("sticky_ovf16",    32'(ov16),     1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
